// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the five-stage Minisys-1A pipeline. It
// generates the write enables and bubble-insert controls of the PC, IF/ID,
// ID/EX and EX/MEM registers. It handles:
//   - load-use hazards (one-cycle stall),
//   - taken branches and jumps resolved in EX (flush IF/ID and ID/EX),
//   - the busy window of the multi-cycle divider,
//   - exception/eret redirection (three cycles of full flush).
// State updates on the falling clock edge, the same edge the pipeline
// registers use. All outputs are combinational from the current inputs and
// the registered state, so the controls act in the cycle they are needed.
//
// Parameters
//   DIV_CYCLES     divider occupancy in cycles (legal range 2..63)
//
// Ports
//   clock          pipeline clock; state updates on negedge
//   reset          synchronous, active-high reset
//   id_rs/id_rt    source register numbers of the instruction in ID
//   id_uses_rs/rt  the ID instruction reads rs / rt
//   id_div         div/divu decoded in ID
//   id_hilo        mfhi/mflo/mthi/mtlo decoded in ID
//   ex_load        EX instruction is a load
//   ex_reg_write   EX instruction writes the register file
//   ex_wb_addr     EX write-back register number
//   ex_redirect    taken branch / jump resolved in EX
//   exception_req  exception or eret accepted this cycle
//   pc_write       PC load enable
//   if_id_write    IF/ID load enable
//   if_id_flush    IF/ID loads a NOP
//   id_ex_flush    ID/EX loads its bubble value
//   ex_mem_flush   EX/MEM loads a bubble
//   pc_sel_exc     PC mux selects exception vector / EPC
//   div_busy       divider occupied
//   div_abort      one-cycle pulse: divide cancelled by an exception
//   state          00 RUN, 01 DIV_WAIT, 10 EXC1, 11 EXC2
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_div,
    input  logic       id_hilo,
    input  logic       ex_load,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_wb_addr,
    input  logic       ex_redirect,
    input  logic       exception_req,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       pc_sel_exc,
    output logic       div_busy,
    output logic       div_abort,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_DIV_WAIT = 2'b01;
    localparam logic [1:0] ST_EXC1     = 2'b10;
    localparam logic [1:0] ST_EXC2     = 2'b11;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;

    logic w_luh;
    logic w_dvh;
    logic w_stall;
    logic w_busy;
    logic w_in_exc;
    logic w_exc_take;
    logic w_div_issue;

    // Hazard detection and sequencing qualifiers.
    always_comb begin
        w_busy   = (r_state == ST_DIV_WAIT);
        // EXC1 and EXC2 are the two states with the top bit set.
        w_in_exc = r_state[1];
        // A request is only accepted outside the exception sequence.
        w_exc_take = exception_req & ~w_in_exc;

        // Register 0 is hard-wired, so a load targeting it never creates a hazard.
        w_luh = ex_load & ex_reg_write & (ex_wb_addr != 5'd0) &
                ((id_uses_rs & (id_rs == ex_wb_addr)) |
                 (id_uses_rt & (id_rt == ex_wb_addr)));
        w_dvh   = w_busy & (id_div | id_hilo);
        w_stall = w_luh | w_dvh;

        w_div_issue = (r_state == ST_RUN) & id_div & ~w_stall &
                      ~ex_redirect & ~exception_req;
    end

    // Next-state and divide-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_exc_take) begin
                    w_state_nxt = ST_EXC1;
                    w_cnt_nxt   = 6'd0;
                end else if (w_div_issue) begin
                    w_state_nxt = ST_DIV_WAIT;
                    w_cnt_nxt   = DIV_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 6'd0;
                end
            end
            ST_DIV_WAIT: begin
                if (exception_req) begin
                    // Abandon the divide; the counter restarts clean.
                    w_state_nxt = ST_EXC1;
                    w_cnt_nxt   = 6'd0;
                end else if (r_cnt <= 6'd1) begin
                    // <= also recovers from a corrupted zero count.
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 6'd0;
                end else begin
                    w_state_nxt = ST_DIV_WAIT;
                    w_cnt_nxt   = r_cnt - 6'd1;
                end
            end
            ST_EXC1: begin
                w_state_nxt = ST_EXC2;
                w_cnt_nxt   = 6'd0;
            end
            ST_EXC2: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 6'd0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    // State and counter registers, clocked on the pipeline's falling edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pipeline control outputs, resolved by priority.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel_exc   = 1'b0;
        div_busy     = 1'b0;
        div_abort    = 1'b0;
        if (reset) begin
            // Hold the front end and bubble every stage while in reset.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            div_busy  = w_busy;
            div_abort = w_busy & exception_req;
            if (exception_req | w_in_exc) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                // The vector is loaded once, in the accepting cycle only.
                pc_sel_exc   = w_exc_take;
            end else if (ex_redirect) begin
                // The ID instruction is on the wrong path: flush it, never hold it.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for pipeline_hazard_ctrl (DIV_CYCLES = 4).
// The driver applies one directed vector per cycle just after the rising
// edge and pushes the hand-computed expected outputs into a queue. A
// separate monitor pops and compares a little later in the same cycle,
// before the falling edge where the DUT state updates.
// Expected word: {pc_write, if_id_write, if_id_flush, id_ex_flush,
//                 ex_mem_flush, pc_sel_exc, div_busy, div_abort, state[1:0]}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    bit         clock;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_wb_addr;
    logic       id_uses_rs, id_uses_rt, id_div, id_hilo;
    logic       ex_load, ex_reg_write, ex_redirect, exception_req;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic       pc_sel_exc, div_busy, div_abort;
    logic [1:0] state;

    // Staged inputs for the next vector.
    logic       s_reset;
    logic [4:0] s_rs, s_rt, s_wb;
    logic       s_urs, s_urt, s_div, s_hilo, s_load, s_rw, s_redir, s_exc;

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    pipeline_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_div(id_div), .id_hilo(id_hilo),
        .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_wb_addr(ex_wb_addr),
        .ex_redirect(ex_redirect), .exception_req(exception_req),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_sel_exc(pc_sel_exc),
        .div_busy(div_busy), .div_abort(div_abort), .state(state)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [9:0] e_norm(input logic b, input logic [1:0] s);
        return {2'b11, 3'b000, 1'b0, b, 1'b0, s};
    endfunction
    function automatic logic [9:0] e_stall(input logic b, input logic [1:0] s);
        return {2'b00, 3'b010, 1'b0, b, 1'b0, s};
    endfunction
    function automatic logic [9:0] e_redir(input logic b, input logic [1:0] s);
        return {2'b11, 3'b110, 1'b0, b, 1'b0, s};
    endfunction
    function automatic logic [9:0] e_exc(input logic p, input logic b, input logic a,
                                         input logic [1:0] s);
        return {2'b11, 3'b111, p, b, a, s};
    endfunction
    function automatic logic [9:0] e_rst(input logic [1:0] s);
        return {2'b00, 3'b111, 1'b0, 1'b0, 1'b0, s};
    endfunction

    task automatic clr_stage();
        s_reset = 1'b0; s_rs = 5'd0; s_rt = 5'd0; s_wb = 5'd0;
        s_urs = 1'b0; s_urt = 1'b0; s_div = 1'b0; s_hilo = 1'b0;
        s_load = 1'b0; s_rw = 1'b0; s_redir = 1'b0; s_exc = 1'b0;
    endtask

    task automatic stage_luh();
        s_load = 1'b1; s_rw = 1'b1; s_wb = 5'd5; s_rs = 5'd5; s_urs = 1'b1;
    endtask

    // Apply the staged vector for one cycle and record what it must produce.
    task automatic step(input logic [9:0] e, input string nm);
        @(posedge clock);
        #1;
        reset = s_reset; id_rs = s_rs; id_rt = s_rt; ex_wb_addr = s_wb;
        id_uses_rs = s_urs; id_uses_rt = s_urt; id_div = s_div; id_hilo = s_hilo;
        ex_load = s_load; ex_reg_write = s_rw; ex_redirect = s_redir;
        exception_req = s_exc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        clr_stage();
    endtask

    // Monitor: compare every pending expectation mid-cycle.
    always @(posedge clock) begin
        logic [9:0] act;
        logic [9:0] e;
        string      nm;
        #3;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
                   pc_sel_exc, div_busy, div_abort, state};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, e, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        clr_stage();
        reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_wb_addr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_div = 1'b0; id_hilo = 1'b0;
        ex_load = 1'b0; ex_reg_write = 1'b0; ex_redirect = 1'b0; exception_req = 1'b0;
        repeat (2) @(negedge clock);

        s_reset = 1'b1;                 step(e_rst(2'b00), "reset_hold");
                                        step(e_norm(1'b0, 2'b00), "idle");
        // Load-use hazard
        stage_luh();                    step(e_stall(1'b0, 2'b00), "luh_rs");
                                        step(e_norm(1'b0, 2'b00), "luh_release");
        stage_luh(); s_wb = 5'd0; s_rs = 5'd0;
                                        step(e_norm(1'b0, 2'b00), "luh_r0");
        s_load = 1'b1; s_rw = 1'b1; s_wb = 5'd7; s_rt = 5'd7; s_urt = 1'b1;
                                        step(e_stall(1'b0, 2'b00), "luh_rt");
        s_load = 1'b1; s_rw = 1'b1; s_wb = 5'd7; s_rt = 5'd7;
                                        step(e_norm(1'b0, 2'b00), "luh_rt_unused");
        stage_luh(); s_rw = 1'b0;       step(e_norm(1'b0, 2'b00), "luh_no_write");
        // Redirect beats the load-use stall
        stage_luh(); s_redir = 1'b1;    step(e_redir(1'b0, 2'b00), "redirect_luh");
        // Divide: busy for 4 cycles, mfhi stalled throughout
        s_div = 1'b1;                   step(e_norm(1'b0, 2'b00), "div_issue");
        for (int i = 0; i < 4; i++) begin
            s_hilo = 1'b1;              step(e_stall(1'b1, 2'b01), "div_hilo_stall");
        end
        s_hilo = 1'b1;                  step(e_norm(1'b0, 2'b00), "div_hilo_release");
        // Divide blocked by load-use, issued after the stall
        stage_luh(); s_div = 1'b1;      step(e_stall(1'b0, 2'b00), "div_blocked_luh");
        s_div = 1'b1;                   step(e_norm(1'b0, 2'b00), "div_issue2");
        s_div = 1'b1;                   step(e_stall(1'b1, 2'b01), "div_in_wait");
        // Exception on the second busy cycle
        s_exc = 1'b1;                   step(e_exc(1'b1, 1'b1, 1'b1, 2'b01), "exc_mid_div");
        s_exc = 1'b1;                   step(e_exc(1'b0, 1'b0, 1'b0, 2'b10), "exc1_ignore_req");
                                        step(e_exc(1'b0, 1'b0, 1'b0, 2'b11), "exc2");
                                        step(e_norm(1'b0, 2'b00), "exc_done");
        // Fresh divide after abort runs the full window
        s_div = 1'b1;                   step(e_norm(1'b0, 2'b00), "div_issue3");
        for (int i = 0; i < 4; i++) begin
                                        step(e_norm(1'b1, 2'b01), "div_busy_window");
        end
                                        step(e_norm(1'b0, 2'b00), "div_window_end");
        // Exception in RUN outranks redirect and stall; reset in EXC1
        stage_luh(); s_redir = 1'b1; s_exc = 1'b1;
                                        step(e_exc(1'b1, 1'b0, 1'b0, 2'b00), "exc_run");
        s_reset = 1'b1;                 step(e_rst(2'b10), "reset_in_exc1");
                                        step(e_norm(1'b0, 2'b00), "after_reset_exc");
        // Reset in DIV_WAIT: no abort pulse, divide abandoned
        s_div = 1'b1;                   step(e_norm(1'b0, 2'b00), "div_issue4");
        s_reset = 1'b1; s_exc = 1'b1;   step(e_rst(2'b01), "reset_in_div");
        s_div = 1'b1; s_redir = 1'b1;   step(e_redir(1'b0, 2'b00), "div_blocked_redir");
                                        step(e_norm(1'b0, 2'b00), "no_div_after_redir");

        repeat (2) @(posedge clock);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
